// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one shared UART transmitter, one byte per frame.
// Optional post-frame idle gap is compiled in with `define UART_ARB_GAP_EN.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 15,
  parameter int GAP_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW:0] NREQ_W = (IW + 1)'(N_REQ);

`ifdef UART_ARB_GAP_EN
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_grant_id;
  logic [DATA_W-1:0]   r_tx_data;
  logic [TW-1:0]       r_to_cnt;

  logic [IW-1:0]       w_cand [N_REQ];
  logic [N_REQ-1:0]    w_cand_valid;
  logic                w_found;
  logic [IW-1:0]       w_gidx;
  logic                w_accept;
  logic                w_timeout;

  // Candidate gi is the requester (ptr + 1 + gi) mod N_REQ, so slot 0 has top priority.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [IW:0] w_sum;
      assign w_sum            = {1'b0, r_ptr} + (IW + 1)'(gi + 1);
      assign w_cand[gi]       = (w_sum >= NREQ_W) ? IW'(w_sum - NREQ_W) : IW'(w_sum);
      assign w_cand_valid[gi] = req_valid[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_cand_valid[k]) begin
        w_found = 1'b1;
        w_gidx  = w_cand[k];
      end
    end
  end

  assign w_accept  = (r_state == ST_IDLE) && w_found;
  assign w_timeout = (r_state == ST_LAUNCH) && !tx_busy && (r_to_cnt == TW'(TIMEOUT - 1));
  assign req_ready = w_accept ? (N_REQ'(1) << w_gidx) : '0;
  assign busy      = (r_state != ST_IDLE);
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;

`ifdef UART_ARB_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GW-1:0] r_gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap_cnt <= r_gap_cnt + 1'b1;
    end else begin
      r_gap_cnt <= '0;
    end
  end
`else
  logic w_unused_gap;
  assign w_unused_gap = ^GAP_CYCLES;
`endif

  always_comb begin
    w_state_next = r_state;
    tx_start     = 1'b0;
    timeout_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        tx_start = 1'b1;
        if (tx_busy) begin
          w_state_next = ST_WAIT_DONE;
        end else if (w_timeout) begin
          // Transmitter never acknowledged: drop the byte and rearbitrate.
          timeout_err  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
`ifdef UART_ARB_GAP_EN
        if (!tx_busy) w_state_next = ST_GAP;
`else
        if (!tx_busy) w_state_next = ST_IDLE;
`endif
      end
`ifdef UART_ARB_GAP_EN
      ST_GAP: begin
        if (r_gap_cnt == GW'(GAP_CYCLES - 1)) w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ptr resets to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= IW'(N_REQ - 1);
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_to_cnt   <= '0;
    end else if (w_accept) begin
      r_ptr      <= w_gidx;
      r_grant_id <= w_gidx;
      r_tx_data  <= req_data[w_gidx * DATA_W +: DATA_W];
      r_to_cnt   <= '0;
    end else if ((r_state == ST_LAUNCH) && !tx_busy && !w_timeout) begin
      r_to_cnt   <= r_to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural transmitter model.
// Expectations come from a plain round-robin model over the requester inputs the bench drives.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TO  = 15;
  localparam int GAP = 2;
`ifdef UART_ARB_GAP_EN
  localparam int ENDLAT = GAP + 1;
`else
  localparam int ENDLAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Requester-side stimulus state, shared between main sequence and driver.
  logic [DW-1:0] cur [N];
  int  rem [N];
  int  rise_pct = 100;
  int  drop_pct = 0;
  int  dead_pct = 0;
  bit  force_dead = 1'b0;
  bit  tx_dead = 1'b0;
  int  model_ptr = N - 1;

  typedef struct {
    int          id;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int rem_total();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction

  // Requester driver + reference model: on every accepted handshake, predict the winner.
  initial begin : driver
    logic [N-1:0] hs;
    exp_t e;
    int w;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = '0;
      if (rst) begin
        model_ptr = N - 1;
      end else begin
        hs = req_valid & req_ready;
        if (hs != '0) begin
          w      = pick(req_valid, model_ptr);
          e.id   = w;
          e.data = (w >= 0) ? cur[w] : 8'h00;
          exp_q.push_back(e);
          if (w >= 0) model_ptr = w;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          rem[i]--;
          cur[i] = 8'($urandom);
          req_valid[i] = 1'b0;
        end else if (req_valid[i] && ($urandom_range(99) < drop_pct)) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && (rem[i] > 0) && ($urandom_range(99) < rise_pct)) begin
          req_valid[i] = 1'b1;
        end
        req_data[i*DW +: DW] = cur[i];
      end
    end
  end

  // Transmitter model: busy from the cycle after tx_start for 2..5 cycles, or dead (never busy).
  initial begin : xmtr
    int cnt;
    bit busy_n;
    bit dwait;
    cnt = 0; busy_n = 1'b0; dwait = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_n = 1'b0; dwait = 1'b0; cnt = 0;
      end else if (busy_n) begin
        cnt--;
        if (cnt == 0) busy_n = 1'b0;
      end else if (dwait) begin
        if (!tx_start) dwait = 1'b0;
      end else if (tx_start) begin
        tx_dead    = force_dead || ($urandom_range(99) < dead_pct);
        force_dead = 1'b0;
        if (tx_dead) begin
          dwait = 1'b1;
        end else begin
          busy_n = 1'b1;
          cnt    = $urandom_range(5, 2);
        end
      end
      @(posedge clk);
      #1;
      tx_busy = busy_n;
    end
  end

  // Monitor: pops expectations on each launch and checks handshake/timing rules.
  initial begin : monitor
    bit p_start, p_busy, last_err, armed;
    int run, since;
    exp_t e;
    p_start = 1'b0; p_busy = 1'b0; last_err = 1'b0; armed = 1'b0;
    run = 0; since = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_start = 1'b0; p_busy = 1'b0; armed = 1'b0; run = 0;
        exp_q.delete();
        continue;
      end
      if (req_ready != '0) begin
        chk("ready_onehot", $countones(req_ready), 1);
        chk("ready_only_in_idle", int'(busy), 0);
      end
      if (timeout_err && !tx_start) chk("err_outside_launch", int'(timeout_err), 0);
      if (tx_start && !p_start) begin
        if (exp_q.size() == 0) begin
          chk("start_without_accept", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", int'(tx_data), int'(e.data));
          chk("grant_id", int'(grant_id), e.id);
        end
        run = 1;
        last_err = timeout_err;
      end else if (tx_start) begin
        run++;
        last_err = timeout_err;
      end else if (p_start) begin
        chk("start_len", run, tx_dead ? TO : 2);
        chk("timeout_pulse", int'(last_err), int'(tx_dead));
        if (tx_dead) chk("idle_after_timeout", int'(busy), 0);
      end
      if (armed) begin
        since++;
`ifdef UART_ARB_GAP_EN
        if (since == GAP) chk("gap_hold_busy", int'(busy), 1);
`endif
        if (since == ENDLAT) begin
          chk("idle_after_frame", int'(busy), 0);
          armed = 1'b0;
        end
      end
      if (p_busy && !tx_busy && busy) begin
        armed = 1'b1;
        since = 0;
      end
      p_start = tx_start;
      p_busy  = tx_busy;
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    bit done = 1'b0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
      if (rem_total() == 0 && !busy && req_valid == '0 && exp_q.size() == 0) done = 1'b1;
    end
    chk(name, int'(done), 1);
  endtask

  task automatic wait_frame(input string name, input int budget);
    int c = 0;
    bit done = 1'b0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
      if (busy && tx_busy && !tx_start) done = 1'b1;
    end
    chk(name, int'(done), 1);
  endtask

  initial begin : main
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      cur[i] = '0;
      rem[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request from requester 0.
    cur[0] = 8'hA5;
    rem[0] = 1;
    wait_idle("single_done", 200);

    // All requesters continuously valid: round robin.
    for (int i = 0; i < N; i++) rem[i] = 5;
    wait_idle("rr_done", 2000);

    // Dead transmitter for one launch, then the following requester.
    force_dead = 1'b1;
    rem[1] = 1;
    rem[2] = 1;
    wait_idle("timeout_done", 500);

    // Requester 2 arrives mid-frame and must wait for IDLE.
    rem[0] = 1;
    wait_frame("block_reach_frame", 100);
    cur[2] = 8'h3C;
    rem[2] = 1;
    wait_idle("block_done", 300);

    // Random traffic with withdrawals and occasional dead launches.
    rise_pct = 60;
    drop_pct = 10;
    dead_pct = 10;
    for (int i = 0; i < N; i++) rem[i] = $urandom_range(8, 3);
    wait_idle("random_done", 8000);
    rise_pct = 100;
    drop_pct = 0;
    dead_pct = 0;

    // Reset in the middle of a frame; requester 0 must win afterwards.
    rem[1] = 1;
    rem[3] = 1;
    wait_frame("reset_reach_frame", 100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx_start", int'(tx_start), 0);
    chk("rst_mid_busy", int'(busy), 0);
    cur[0] = 8'h5A;
    rem[0] = 1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle("post_reset_done", 500);

    chk("all_delivered", rem_total(), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
